// File: rtl/fifo_pkg.sv
// Shared types and helpers for the 8-bit synchronous fifo and its read-side engines.
// Optional feature macro used by consumers: FIFO_DRAIN_PARITY_EN.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_W = 8;
    localparam int unsigned FIFO_CNT_W  = 4;

    typedef enum logic {
        DRAIN_IDLE,
        DRAIN_ACTIVE
    } drain_state_t;

    // Odd parity bit: XOR of word and result is always 1 (zero-extension is harmless).
    function automatic logic odd_parity(input logic [63:0] word);
        return ~(^word);
    endfunction

endpackage

// File: rtl/fifo_drain_skid.sv
// Two-entry in-order skid buffer between the FIFO read port and the output stream.
// With FIFO_DRAIN_PARITY_EN defined each entry also carries an odd-parity bit.
module fifo_drain_skid
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [1:0]        occ,
    output logic              valid,
    output logic [DATA_W-1:0] dout
`ifdef FIFO_DRAIN_PARITY_EN
    ,
    output logic              dout_par
`endif
);

`ifdef FIFO_DRAIN_PARITY_EN
    localparam int unsigned ENT_W = DATA_W + 1;
`else
    localparam int unsigned ENT_W = DATA_W;
`endif

    logic [ENT_W-1:0] ent_in;
    logic [ENT_W-1:0] head;
    logic [ENT_W-1:0] tail;

`ifdef FIFO_DRAIN_PARITY_EN
    assign ent_in = {odd_parity(64'(din)), din};
`else
    assign ent_in = din;
`endif

    // head is always the oldest word; tail only holds a word when occ == 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            occ  <= 2'd0;
        end else begin
            case (occ)
                2'd0: begin
                    if (push) begin
                        head <= ent_in;
                        occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= ent_in;
                    end else if (push) begin
                        tail <= ent_in;
                        occ  <= 2'd2;
                    end else if (pop) begin
                        occ  <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head <= tail;
                        if (push) begin
                            tail <= ent_in;
                        end else begin
                            occ  <= 2'd1;
                        end
                    end
                end
                default: occ <= 2'd0;
            endcase
        end
    end

    assign valid = (occ != 2'd0);
    assign dout  = head[DATA_W-1:0];
`ifdef FIFO_DRAIN_PARITY_EN
    assign dout_par = head[DATA_W];
`endif

endmodule

// File: rtl/fifo_drain.sv
// Read-side drain engine: threshold/flush-triggered burst reads from the fifo into a
// valid/ready stream via a 2-entry skid buffer. FIFO_DRAIN_PARITY_EN adds m_parity.
module fifo_drain
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W,
    parameter int unsigned CNT_W  = FIFO_CNT_W,
    parameter int unsigned THRESH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [CNT_W-1:0]  fifo_cnt,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    input  logic              flush,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              busy
`ifdef FIFO_DRAIN_PARITY_EN
    ,
    output logic              m_parity
`endif
);

    drain_state_t state;
    drain_state_t state_nxt;
    logic         inflight;
    logic [1:0]   occ;
    logic         pop;
    logic [2:0]   committed;
    logic         trigger;

    assign pop = m_valid && m_ready;

    // Words buffered or in flight after this cycle's pop; reads stop at 2 so the skid never overflows.
    assign committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rd   = (state == DRAIN_ACTIVE) && !fifo_empty && (committed < 3'd2);

    assign trigger = (fifo_cnt >= CNT_W'(THRESH)) || (flush && !fifo_empty);

    always_comb begin
        state_nxt = state;
        case (state)
            DRAIN_IDLE: begin
                if (trigger) begin
                    state_nxt = DRAIN_ACTIVE;
                end
            end
            DRAIN_ACTIVE: begin
                if (fifo_empty && !inflight && !fifo_rd) begin
                    state_nxt = DRAIN_IDLE;
                end
            end
            default: state_nxt = DRAIN_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= DRAIN_IDLE;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= fifo_rd;
        end
    end

    fifo_drain_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst),
        .push     (inflight),
        .din      (fifo_data),
        .pop      (pop),
        .occ      (occ),
        .valid    (m_valid),
        .dout     (m_data)
`ifdef FIFO_DRAIN_PARITY_EN
        ,
        .dout_par (m_parity)
`endif
    );

    assign busy = (state == DRAIN_ACTIVE) || (occ != 2'd0) || inflight;

endmodule

// File: tb/tb_fifo_drain.sv
// Self-checking bench for fifo_drain: behavioural FIFO, in-order scoreboard of written words,
// stream protocol monitor, directed steps followed by randomized bursts.
module tb_fifo_drain;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned TH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [CW-1:0] fifo_cnt = '0;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd;
    logic          flush = 1'b0;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b0;
    logic          busy;
`ifdef FIFO_DRAIN_PARITY_EN
    logic          m_parity;
`endif

    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            out_cnt = 0;
    logic          hold = 1'b0;
    logic [DW-1:0] hold_data = '0;
    logic          rd_now;
    logic          pop_now;
    logic [DW-1:0] want;

    fifo_drain #(
        .DATA_W (DW),
        .CNT_W  (CW),
        .THRESH (TH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_cnt   (fifo_cnt),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .busy       (busy)
`ifdef FIFO_DRAIN_PARITY_EN
        ,
        .m_parity   (m_parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [DW-1:0] v);
        fq.push_back(v);
        exp_q.push_back(v);
        fifo_cnt   = CW'(fq.size());
        fifo_empty = 1'b0;
    endtask

    // Behavioural FIFO: registered read data, one-cycle latency.
    always @(posedge clk) begin
        if (rst && fifo_rd && !fifo_empty && fq.size() != 0) begin
            fifo_data <= fq.pop_front();
        end
        fifo_cnt   <= CW'(fq.size());
        fifo_empty <= (fq.size() == 0);
    end

    // Stream monitor: ordering, hold stability, outstanding-read bound, empty guard, parity.
    always @(negedge clk) begin
        if (!rst) begin
            out_cnt = 0;
            hold    = 1'b0;
        end else begin
            rd_now  = fifo_rd && !fifo_empty;
            pop_now = m_valid && m_ready;
            check("rd_while_empty", 32'(fifo_rd && fifo_empty), 32'd0);
            if (hold) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", 32'(m_data), 32'(hold_data));
            end
            if (pop_now) begin
                if (exp_q.size() == 0) begin
                    check("spurious_word", 32'(exp_q.size()), 32'd1);
                end else begin
                    want = exp_q.pop_front();
                    check("order", 32'(m_data), 32'(want));
                end
            end
`ifdef FIFO_DRAIN_PARITY_EN
            if (m_valid) begin
                check("parity", 32'(m_parity), 32'(($countones(m_data) % 2) == 0));
            end
`endif
            out_cnt = out_cnt + int'(rd_now) - int'(pop_now);
            if (rd_now) begin
                check("outstanding", 32'(out_cnt <= 2), 32'd1);
            end
            hold      = m_valid && !m_ready;
            hold_data = m_data;
        end
    end

    task automatic wait_idle(input int mode, input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            case (mode)
                1: m_ready = ~m_ready;
                2: m_ready = 1'($urandom_range(0, 1));
                default: ;
            endcase
            @(negedge clk);
            if (!busy && fq.size() == 0 && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            bad;
        bit            got;
        int            k;
        logic [DW-1:0] a;
        logic [DW-1:0] b;

        // Reset held with a full-enough FIFO: outputs stay quiet.
        for (int i = 0; i < 8; i++) wr(8'($urandom));
        @(negedge clk);
        @(negedge clk);
        check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef FIFO_DRAIN_PARITY_EN
        check("rst_m_parity", 32'(m_parity), 32'd0);
`endif
        step();
        rst = 1'b1;
        @(negedge clk);
        check("rd_before_first_edge", 32'(fifo_rd), 32'd0);
        step();
        @(negedge clk);
        check("rd_second_edge", 32'(fifo_rd), 32'd1);
        step();
        m_ready = 1'b1;
        wait_idle(0, "reset_drain_idle");

        // Threshold trigger: three words do not start a burst, the fourth does.
        step(); wr(8'd42);
        step(); wr(8'd30);
        step(); wr(8'd55);
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (fifo_rd) bad = 1'b1;
        end
        check("thr_below_no_rd", 32'(bad), 32'd0);
        step(); wr(8'd87);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("thr_first_pop", 32'(got), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("thr_consecutive", 32'(m_valid && m_ready), 32'd1);
        end
        wait_idle(0, "thr_idle");
        check("thr_busy_low", 32'(busy), 32'd0);
        check("thr_valid_low", 32'(m_valid), 32'd0);

        // Below threshold: no reads until flush is pulsed.
        step(); wr(8'd30);
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (fifo_rd) bad = 1'b1;
        end
        check("below_no_rd", 32'(bad), 32'd0);
        step(); flush = 1'b1;
        step(); flush = 1'b0;
        wait_idle(0, "flush_idle");
        check("flush_drained", 32'(exp_q.size()), 32'd0);

        // Back-pressure: m_ready toggles every cycle.
        for (int i = 1; i <= 8; i++) begin
            step();
            wr(8'(i));
            m_ready = ~m_ready;
        end
        wait_idle(1, "bp_idle");

        // Empty guard: two words pulled into the skid with the stream stalled.
        a = 8'($urandom);
        b = 8'($urandom);
        step(); m_ready = 1'b0; wr(a);
        step(); wr(b); flush = 1'b1;
        repeat (10) step();
        flush = 1'b0;
        @(negedge clk);
        check("guard_fifo_empty", 32'(fifo_empty), 32'd1);
        check("guard_valid", 32'(m_valid), 32'd1);
        check("guard_head", 32'(m_data), 32'(a));
        check("guard_busy", 32'(busy), 32'd1);
        check("guard_held", 32'(out_cnt), 32'd2);
        step(); m_ready = 1'b1;
        wait_idle(0, "guard_release_idle");

`ifdef FIFO_DRAIN_PARITY_EN
        step(); wr(8'h00);
        step(); wr(8'h01);
        step(); wr(8'hFF); flush = 1'b1;
        wait_idle(0, "parity_idle");
        flush = 1'b0;
`endif

        // Randomized bursts with random back-pressure and flush.
        for (int r = 0; r < 8; r++) begin
            k = int'($urandom_range(1, 10));
            for (int j = 0; j < k; j++) begin
                step();
                m_ready = 1'($urandom_range(0, 1));
                flush   = ($urandom_range(0, 3) == 0);
                if (fq.size() < 14) wr(8'($urandom));
            end
            step();
            flush = 1'b1;
            wait_idle(2, "rand_idle");
            flush = 1'b0;
        end
        check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
